// File: rtl/neuron_accumulator.sv
// -----------------------------------------------------------------------------
// neuron_accumulator
//
// Sums N_INPUTS unsigned weighted products and then presents one activated
// neuron output. While collecting products the block is ready for input. After
// the last product is accepted, the block holds Result/Fire until the
// downstream consumer takes them.
//
// Activation: if sum > bias, then result = min(sum - bias, 0xFFFFFFFF) and
// fire = 1. Otherwise result = 0 and fire = 0.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   in_data carries a product this cycle
//   in_ready   out  1   block accepts a product this cycle (ACCUM state)
//   in_data    in  32   unsigned weighted product
//   bias       in  32   unsigned threshold, sampled on the edge entering HOLD
//   out_valid  out  1   result/fire valid (HOLD state)
//   out_ready  in   1   downstream accepts result/fire
//   result     out 32   activated output, saturating
//   fire       out  1   sum strictly exceeded bias
// -----------------------------------------------------------------------------
module neuron_accumulator #(
  parameter int N_INPUTS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [31:0] bias,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        fire
);

  localparam int CNT_W = $clog2(N_INPUTS);
  localparam int ACC_W = 32 + CNT_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_INPUTS - 1);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t             state_r, state_next_s;
  logic [ACC_W-1:0]   accum_r, accum_next_s, sum_s;
  logic [CNT_W-1:0]   count_r, count_next_s;
  logic [31:0]        result_r, result_next_s;
  logic               fire_r, fire_next_s;
  logic [32:0]        act_s;

  // Activation: returns {fire, result}. The accumulator is wide enough that
  // the difference can exceed 32 bits, in which case the result clamps.
  function automatic logic [32:0] activate(input logic [ACC_W-1:0] sum,
                                           input logic [31:0]      thr);
    logic [ACC_W-1:0] thr_ext;
    logic [ACC_W-1:0] diff;
    logic [32:0]      ret;
    thr_ext = {{CNT_W{1'b0}}, thr};
    diff    = sum - thr_ext;
    if (sum > thr_ext) begin
      if (|diff[ACC_W-1:32]) begin
        ret = {1'b1, 32'hFFFF_FFFF};
      end else begin
        ret = {1'b1, diff[31:0]};
      end
    end else begin
      ret = 33'd0;
    end
    return ret;
  endfunction

  // Running sum including the product offered this cycle; cannot overflow.
  assign sum_s = accum_r + {{CNT_W{1'b0}}, in_data};
  assign act_s = activate(sum_s, bias);

  // Handshake flags are direct decodes of the state register.
  assign in_ready  = (state_r == ACCUM);
  assign out_valid = (state_r == HOLD);
  assign result    = result_r;
  assign fire      = fire_r;

  // Next-state and datapath update for the ACCUM/HOLD controller.
  always_comb begin
    state_next_s  = state_r;
    accum_next_s  = accum_r;
    count_next_s  = count_r;
    result_next_s = result_r;
    fire_next_s   = fire_r;
    case (state_r)
      ACCUM: begin
        if (in_valid) begin
          accum_next_s = sum_s;
          if (count_r == CNT_LAST) begin
            // Last beat: activation uses the sum including this beat.
            state_next_s  = HOLD;
            result_next_s = act_s[31:0];
            fire_next_s   = act_s[32];
          end else begin
            count_next_s = count_r + CNT_W'(1'b1);
          end
        end else begin
          accum_next_s = accum_r;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_next_s = ACCUM;
          accum_next_s = {ACC_W{1'b0}};
          count_next_s = {CNT_W{1'b0}};
        end else begin
          state_next_s = HOLD;
        end
      end
      default: begin
        state_next_s = ACCUM;
        accum_next_s = {ACC_W{1'b0}};
        count_next_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, accumulator, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ACCUM;
      accum_r  <= {ACC_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      result_r <= 32'd0;
      fire_r   <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      accum_r  <= accum_next_s;
      count_r  <= count_next_s;
      result_r <= result_next_s;
      fire_r   <= fire_next_s;
    end
  end

endmodule

// File: tb/tb_neuron_accumulator.sv
module tb_neuron_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'd0;
  logic [31:0] bias = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        fire;

  int errors = 0;
  int checks = 0;
  logic [32:0] exp_q[$];

  neuron_accumulator #(.N_INPUTS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .bias(bias), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .fire(fire)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c, input logic [31:0] d,
                                        input logic [31:0] bs);
    logic [63:0] s;
    s = 64'(a) + 64'(b) + 64'(c) + 64'(d);
    if (s > 64'(bs)) begin
      s = s - 64'(bs);
      if (s > 64'h0000_0000_FFFF_FFFF) s = 64'h0000_0000_FFFF_FFFF;
      return {1'b1, s[31:0]};
    end
    return 33'd0;
  endfunction

  // Called at a negedge; returns at the negedge after the 4th beat is accepted.
  task automatic drive_neuron(input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3,
                              input logic [31:0] b, input int gap_pct);
    logic [31:0] d[4];
    d = '{d0, d1, d2, d3};
    bias = b;
    exp_q.push_back(model(d0, d1, d2, d3, b));
    for (int i = 0; i < 4; i++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL gap_out_valid: got %b want 0", out_valid);
        end
      end
      in_valid = 1'b1;
      in_data  = d[i];
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL beat_in_ready[%0d]: got %b want 1", i, in_ready);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL latency: out_valid=%b in_ready=%b want 1/0", out_valid, in_ready);
    end
  endtask

  // Bounded wait for out_valid, compare against scoreboard, complete handshake.
  task automatic wait_output(input string name);
    int guard = 0;
    logic [32:0] exp;
    while (out_valid !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 100 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_timeout: out_valid=%b queued=%0d", name, out_valid, exp_q.size());
      return;
    end
    exp = exp_q.pop_front();
    checks++;
    if ({fire, result} !== exp) begin
      errors++;
      $display("FAIL %s_result: got fire=%b result=%h want fire=%b result=%h",
               name, fire, result, exp[32], exp[31:0]);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_release: out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || result !== 32'd0 || fire !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b result=%h fire=%b want 0/0/0", out_valid, result, fire);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    // out_ready while nothing is held must do nothing
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL idle_out_ready: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_activation();
    drive_neuron(32'd5, 32'd6, 32'd7, 32'd8, 32'd10, 0);
    wait_output("fire16");
    drive_neuron(32'd1, 32'd2, 32'd3, 32'd4, 32'd100, 0);
    wait_output("nofire");
    drive_neuron(32'd5, 32'd6, 32'd7, 32'd8, 32'd26, 0);
    wait_output("equal_bias");
    drive_neuron(32'd5, 32'd6, 32'd7, 32'd8, 32'd25, 0);
    wait_output("just_above");
    drive_neuron(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 0);
    wait_output("saturate");
    drive_neuron(32'hFFFF_FFFF, 32'h0000_0001, 32'd0, 32'd0, 32'd1, 0);
    wait_output("exact_max");
  endtask

  task automatic test_hold_stall();
    logic [32:0] exp;
    drive_neuron(32'd5, 32'd6, 32'd7, 32'd8, 32'd10, 0);
    exp = exp_q[0];
    in_valid = 1'b1;
    in_data  = 32'd99;
    for (int i = 0; i < 5; i++) begin
      bias = $urandom;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {fire, result} !== exp) begin
        errors++;
        $display("FAIL hold_stable[%0d]: ov=%b ir=%b fire=%b result=%h want 1/0/%b/%h",
                 i, out_valid, in_ready, fire, result, exp[32], exp[31:0]);
      end
    end
    wait_output("hold_stall");
    // a leaked beat or stale accumulator would corrupt this result
    drive_neuron(32'd5, 32'd6, 32'd7, 32'd8, 32'd10, 0);
    wait_output("after_stall");
  endtask

  task automatic test_gaps();
    for (int r = 0; r < 4; r++) begin
      drive_neuron(32'd5, 32'd6, 32'd7, 32'd8, 32'd10, 50);
      wait_output("gaps");
    end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1;
    in_data  = 32'd9;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 32'd0 || fire !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: ov=%b result=%h fire=%b want 0/0/0", out_valid, result, fire);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive_neuron(32'd1, 32'd1, 32'd1, 32'd1, 32'd0, 0);
    wait_output("post_reset");
    // reset while holding a result discards it
    drive_neuron(32'd50, 32'd50, 32'd50, 32'd50, 32'd0, 0);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    checks++;
    if (out_valid !== 1'b0 || fire !== 1'b0) begin
      errors++;
      $display("FAIL hold_reset: ov=%b fire=%b want 0/0", out_valid, fire);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    drive_neuron(32'd10, 32'd20, 32'd30, 32'd40, 32'd1, 0);
    wait_output("b2b_a");
    drive_neuron(32'd3, 32'd3, 32'd3, 32'd3, 32'd5, 0);
    wait_output("b2b_b");
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d entries want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_activation();
    test_hold_stall();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
